liteic_slave_node_write_rr: RTL and testbench
=============================================

Name: liteic_slave_node_write_rr

Overview:
Write-path node for one interconnect slave port. It arbitrates AW requests from NUM_MST crossbar master slots using a round-robin arbiter, restricted by the CONNECTIVITY mask. It allows up to MAX_OUTSTANDING write transactions in flight and steers W and B to the correct master in AW-acceptance order. It replaces the single-outstanding fixed-priority write node and sits between the crossbar matrix and the slave AXI-Lite port.

Parameters:
NUM_MST, 4, number of crossbar master slots.
CONNECTIVITY, '1 (NUM_MST bits), bit i=1 means master slot i may reach this slave; unconnected slots are never granted and get rdy/val = 0.
AWADDR_W, 32, AW address width.
WDATA_W, 36, W payload width ({strb,data} packed).
BRESP_W, 2, B response width.
MAX_OUTSTANDING, 4, maximum in-flight writes (AW accepted, B not yet done); must be >= 1.
ID_W, $clog2(NUM_MST) (min 1), localparam, master index width.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
cbar_aw_data_i  in  AWADDR_W x [NUM_MST]  per-master AW address
cbar_aw_val_i  in  NUM_MST  per-master AW valid
cbar_aw_rdy_o  out  NUM_MST  per-master AW ready
cbar_w_data_i  in  WDATA_W x [NUM_MST]  per-master W payload
cbar_w_val_i  in  NUM_MST  per-master W valid
cbar_w_rdy_o  out  NUM_MST  per-master W ready
cbar_b_val_o  out  NUM_MST  per-master B valid
cbar_b_rdy_i  in  NUM_MST  per-master B ready
cbar_b_data_o  out  BRESP_W  B response (shared by all masters)
slv_aw_addr_o / slv_aw_valid_o  out  AWADDR_W / 1  slave AW
slv_aw_ready_i  in  1  slave AW ready
slv_w_data_o / slv_w_valid_o  out  WDATA_W / 1  slave W
slv_w_ready_i  in  1  slave W ready
slv_b_resp_i / slv_b_valid_i  in  BRESP_W / 1  slave B
slv_b_ready_o  out  1  slave B ready
outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  in-flight write count
b_err_o  out  1  sticky flag: slave asserted B valid with no write outstanding

Behaviour:
- Reset (rst_i high at clk_i edge): all valid/ready outputs 0, outstanding_o 0, b_err_o 0. Both order FIFOs empty, w_ahead 0, grant lock cleared, RR pointer at slot 0 (slot 0 has highest priority).
- Datapath is combinational; there is zero-cycle latency from crossbar to slave and back.
- AW arbitration:
  - Requests = cbar_aw_val_i & CONNECTIVITY.
  - Round-robin search starts at the pointer. Once slv_aw_valid_o is high, the grant is locked until the AW handshake, so slv_aw_addr_o stays stable.
  - On an AW handshake the pointer moves to winner+1, wrapping at NUM_MST.
- slv_aw_valid_o = any request & !full, where full = (outstanding == MAX_OUTSTANDING).
  - There is no same-cycle credit from a B handshake: at full, AW is blocked for that cycle.
  - cbar_aw_rdy_o = onehot(grant) & slv_aw_ready_i & slv_aw_valid_o.
- Order FIFOs: wq and bq, each of depth MAX_OUTSTANDING, holding ID_W-bit master indices.
  - An AW handshake pushes the grant into bq, and into wq unless its W has already completed (see w_ahead).
- W steering: wsel = head(wq) if wq non-empty; otherwise the current AW grant while slv_aw_valid_o=1 and w_ahead=0 (bypass). If neither applies, there is no W.
  - slv_w_valid_o = cbar_w_val_i[wsel] when wsel exists.
  - cbar_w_rdy_o = onehot(wsel) & slv_w_ready_i.
  - A W handshake pops wq when it was sourced from wq.
  - A W handshake via bypass whose AW is not handshaking in the same cycle sets w_ahead. The next AW handshake skips the wq push and clears w_ahead.
  - When bypass AW and W handshake in the same cycle, there is no push and no flag.
- B steering: bsel = head(bq).
  - cbar_b_val_o = onehot(bsel) & slv_b_valid_i when bq is non-empty.
  - slv_b_ready_o = cbar_b_rdy_i[bsel] when bq is non-empty, else 0.
  - cbar_b_data_o = slv_b_resp_i.
  - A B handshake pops bq. slv_b_valid_i with bq empty sets b_err_o; only reset clears it.
- outstanding: +1 on AW handshake, -1 on B handshake, unchanged when both occur in the same cycle. It never exceeds MAX_OUTSTANDING.
- Reset mid-transaction drops all in-flight state. The slave side is expected to be reset together with the node.

Decomposition:
- Shared package liteic_pkg gains: the rr-pointer/ID width helper function, and the default MAX_OUTSTANDING constant IC_WR_MAX_OUTSTANDING.
- Natural sub-module: liteic_rr_arbiter. It takes NUM_MST request bits, a lock and an advance input, and outputs a onehot grant plus an index. It will be reused by the read node.
- The two order FIFOs are an inline register array with pointers and a count.

Test Plan:
- Single write, master 2, addr 0x100, data 0xAB: AW/W forwarded, B OKAY returned to slot 2 only, outstanding goes 0→1→0.
- Masters 0,1,3 hold AW valid continuously, slave always ready: grants are 0,1,3,0,1,3, with no starvation.
- MAX_OUTSTANDING=2 and slave withholds B: the third AW is blocked (slv_aw_valid_o=0). After one B handshake, AW is accepted on the next cycle.
- Two AWs accepted (m1 then m3) and slave takes W late: W is routed from m1 then m3. B responses SLVERR then OKAY go to m1 and m3 respectively.
- Slave holds aw_ready=0 until W arrives: W bypass handshakes first, w_ahead=1. AW is then accepted without a wq push, and no duplicate W is forwarded.
- CONNECTIVITY=4'b1011 with master 2 requesting: no grant, cbar_aw_rdy_o[2] stays 0. slv_b_valid_i=1 when idle: b_err_o=1 until reset.

Source files
------------

// File: rtl/liteic_pkg.sv
// Shared interconnect definitions: index-width helper and write-node defaults.
package liteic_pkg;

    localparam int unsigned IC_WR_MAX_OUTSTANDING = 4;

    // Width of an index over n items, never below one bit.
    function automatic int unsigned ic_idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/liteic_rr_arbiter.sv
// Round-robin arbiter with grant lock; pointer advances past the winner on advance_i.
module liteic_rr_arbiter
    import liteic_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = ic_idx_width(N)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N-1:0]     req_i,
    input  logic             lock_i,
    input  logic             advance_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             vld_o
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] search_idx;
    logic             search_vld;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q      <= '0;
            lock_idx_q <= '0;
            lock_q     <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            lock_idx_q <= lock_idx_d;
            lock_q     <= lock_d;
        end
    end

    // First requester at or after the pointer, wrapping at N.
    always_comb begin : p_search
        int unsigned j;
        j          = 0;
        search_idx = ptr_q;
        search_vld = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            j = 32'(ptr_q) + i;
            if (j >= N) j = j - N;
            if (!search_vld && req_i[IDX_W'(j)]) begin
                search_vld = 1'b1;
                search_idx = IDX_W'(j);
            end
        end
    end

    always_comb begin
        idx_o      = lock_q ? lock_idx_q : search_idx;
        vld_o      = lock_q ? req_i[lock_idx_q] : search_vld;
        gnt_o      = vld_o ? (N'(1) << idx_o) : '0;
        lock_d     = lock_i;
        lock_idx_d = idx_o;
        ptr_d      = ptr_q;
        if (advance_i) begin
            ptr_d = (idx_o == IDX_W'(N - 1)) ? '0 : idx_o + 1'b1;
        end
    end

endmodule

// File: rtl/liteic_slave_node_write_rr.sv
// Slave-port write node: round-robin AW arbitration, multiple writes in flight,
// W and B steered in AW-acceptance order through two index FIFOs.
module liteic_slave_node_write_rr
    import liteic_pkg::*;
#(
    parameter int unsigned        NUM_MST         = 4,
    parameter logic [NUM_MST-1:0] CONNECTIVITY    = '1,
    parameter int unsigned        AWADDR_W        = 32,
    parameter int unsigned        WDATA_W         = 36,
    parameter int unsigned        BRESP_W         = 2,
    parameter int unsigned        MAX_OUTSTANDING = IC_WR_MAX_OUTSTANDING
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [AWADDR_W-1:0]                    cbar_aw_data_i [NUM_MST],
    input  logic [NUM_MST-1:0]                     cbar_aw_val_i,
    output logic [NUM_MST-1:0]                     cbar_aw_rdy_o,
    input  logic [WDATA_W-1:0]                     cbar_w_data_i [NUM_MST],
    input  logic [NUM_MST-1:0]                     cbar_w_val_i,
    output logic [NUM_MST-1:0]                     cbar_w_rdy_o,
    output logic [NUM_MST-1:0]                     cbar_b_val_o,
    input  logic [NUM_MST-1:0]                     cbar_b_rdy_i,
    output logic [BRESP_W-1:0]                     cbar_b_data_o,
    output logic [AWADDR_W-1:0]                    slv_aw_addr_o,
    output logic                                   slv_aw_valid_o,
    input  logic                                   slv_aw_ready_i,
    output logic [WDATA_W-1:0]                     slv_w_data_o,
    output logic                                   slv_w_valid_o,
    input  logic                                   slv_w_ready_i,
    input  logic [BRESP_W-1:0]                     slv_b_resp_i,
    input  logic                                   slv_b_valid_i,
    output logic                                   slv_b_ready_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   b_err_o
);

    localparam int unsigned ID_W  = ic_idx_width(NUM_MST);
    localparam int unsigned PTR_W = ic_idx_width(MAX_OUTSTANDING);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [ID_W-1:0]  wq_mem_q [MAX_OUTSTANDING];
    logic [ID_W-1:0]  wq_mem_d [MAX_OUTSTANDING];
    logic [ID_W-1:0]  bq_mem_q [MAX_OUTSTANDING];
    logic [ID_W-1:0]  bq_mem_d [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wq_wr_q, wq_wr_d, wq_rd_q, wq_rd_d;
    logic [PTR_W-1:0] bq_wr_q, bq_wr_d, bq_rd_q, bq_rd_d;
    logic [CNT_W-1:0] wq_cnt_q, wq_cnt_d, bq_cnt_q, bq_cnt_d;
    logic             w_ahead_q, w_ahead_d;
    logic             b_err_q, b_err_d;

    logic [NUM_MST-1:0] gnt_oh;
    logic [ID_W-1:0]    gnt_idx, wsel, bsel;
    logic               gnt_vld, full, aw_hs;
    logic               wq_ne, bq_ne, w_byp, wsel_vld, w_hs, b_hs;
    logic               wq_push, wq_pop;

    liteic_rr_arbiter #(
        .N     (NUM_MST),
        .IDX_W (ID_W)
    ) u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (cbar_aw_val_i & CONNECTIVITY),
        .lock_i    (slv_aw_valid_o & ~aw_hs),
        .advance_i (aw_hs),
        .gnt_o     (gnt_oh),
        .idx_o     (gnt_idx),
        .vld_o     (gnt_vld)
    );

    // AW: blocked at full, no same-cycle credit from a B handshake.
    always_comb begin
        full           = (bq_cnt_q == CNT_W'(MAX_OUTSTANDING));
        slv_aw_valid_o = gnt_vld & ~full;
        slv_aw_addr_o  = cbar_aw_data_i[gnt_idx];
        aw_hs          = slv_aw_valid_o & slv_aw_ready_i;
        cbar_aw_rdy_o  = aw_hs ? gnt_oh : '0;
    end

    // W: FIFO head first, else bypass to the AW grant unless its W already went.
    always_comb begin
        wq_ne         = (wq_cnt_q != '0);
        w_byp         = ~wq_ne & slv_aw_valid_o & ~w_ahead_q;
        wsel_vld      = wq_ne | w_byp;
        wsel          = wq_ne ? wq_mem_q[wq_rd_q] : gnt_idx;
        slv_w_data_o  = cbar_w_data_i[wsel];
        slv_w_valid_o = wsel_vld & cbar_w_val_i[wsel];
        cbar_w_rdy_o  = (wsel_vld & slv_w_ready_i) ? (NUM_MST'(1) << wsel) : '0;
        w_hs          = slv_w_valid_o & slv_w_ready_i;
        wq_pop        = w_hs & wq_ne;
        wq_push       = aw_hs & ~w_ahead_q & ~(w_hs & w_byp);
    end

    always_comb begin
        bq_ne         = (bq_cnt_q != '0);
        bsel          = bq_mem_q[bq_rd_q];
        cbar_b_val_o  = (bq_ne & slv_b_valid_i) ? (NUM_MST'(1) << bsel) : '0;
        slv_b_ready_o = bq_ne & cbar_b_rdy_i[bsel];
        cbar_b_data_o = slv_b_resp_i;
        b_hs          = slv_b_valid_i & slv_b_ready_o;
        outstanding_o = bq_cnt_q;
        b_err_o       = b_err_q;
    end

    always_comb begin
        wq_mem_d  = wq_mem_q;
        wq_wr_d   = wq_wr_q;
        wq_rd_d   = wq_rd_q;
        wq_cnt_d  = wq_cnt_q;
        bq_mem_d  = bq_mem_q;
        bq_wr_d   = bq_wr_q;
        bq_rd_d   = bq_rd_q;
        bq_cnt_d  = bq_cnt_q;
        w_ahead_d = w_ahead_q;
        b_err_d   = b_err_q | (slv_b_valid_i & ~bq_ne);
        if (wq_push) begin
            wq_mem_d[wq_wr_q] = gnt_idx;
            wq_wr_d           = ptr_inc(wq_wr_q);
        end
        if (wq_pop) wq_rd_d = ptr_inc(wq_rd_q);
        case ({wq_push, wq_pop})
            2'b10:   wq_cnt_d = wq_cnt_q + CNT_W'(1);
            2'b01:   wq_cnt_d = wq_cnt_q - CNT_W'(1);
            default: wq_cnt_d = wq_cnt_q;
        endcase
        if (aw_hs) begin
            bq_mem_d[bq_wr_q] = gnt_idx;
            bq_wr_d           = ptr_inc(bq_wr_q);
        end
        if (b_hs) bq_rd_d = ptr_inc(bq_rd_q);
        case ({aw_hs, b_hs})
            2'b10:   bq_cnt_d = bq_cnt_q + CNT_W'(1);
            2'b01:   bq_cnt_d = bq_cnt_q - CNT_W'(1);
            default: bq_cnt_d = bq_cnt_q;
        endcase
        if (aw_hs)             w_ahead_d = 1'b0;
        else if (w_hs & w_byp) w_ahead_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wq_mem_q  <= '{default: '0};
            bq_mem_q  <= '{default: '0};
            wq_wr_q   <= '0;
            wq_rd_q   <= '0;
            wq_cnt_q  <= '0;
            bq_wr_q   <= '0;
            bq_rd_q   <= '0;
            bq_cnt_q  <= '0;
            w_ahead_q <= 1'b0;
            b_err_q   <= 1'b0;
        end else begin
            wq_mem_q  <= wq_mem_d;
            bq_mem_q  <= bq_mem_d;
            wq_wr_q   <= wq_wr_d;
            wq_rd_q   <= wq_rd_d;
            wq_cnt_q  <= wq_cnt_d;
            bq_wr_q   <= bq_wr_d;
            bq_rd_q   <= bq_rd_d;
            bq_cnt_q  <= bq_cnt_d;
            w_ahead_q <= w_ahead_d;
            b_err_q   <= b_err_d;
        end
    end

endmodule

// File: tb/tb_liteic_slave_node_write_rr.sv
// Directed bench: a fully connected node with two outstanding slots, plus a
// partially connected node sharing the crossbar-side inputs.
module tb_liteic_slave_node_write_rr;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] aw_data [4];
    logic [35:0] w_data  [4];
    logic [3:0]  aw_val, w_val, b_rdy;
    logic [3:0]  aw_rdy, w_rdy, b_val, c_aw_rdy, c_w_rdy, c_b_val;
    logic [1:0]  b_resp, b_data, c_b_data;
    logic [31:0] s_aw_addr, c_aw_addr;
    logic [35:0] s_w_data, c_w_data;
    logic        s_aw_valid, s_aw_ready, s_w_valid, s_w_ready, s_b_valid, s_b_ready;
    logic        c_aw_valid, c_aw_ready, c_w_valid, c_w_ready, c_b_valid, c_b_ready;
    logic [1:0]  outstanding;
    logic [2:0]  c_out;
    logic        b_err, c_b_err;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    liteic_slave_node_write_rr #(.MAX_OUTSTANDING(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .cbar_aw_data_i(aw_data), .cbar_aw_val_i(aw_val), .cbar_aw_rdy_o(aw_rdy),
        .cbar_w_data_i(w_data), .cbar_w_val_i(w_val), .cbar_w_rdy_o(w_rdy),
        .cbar_b_val_o(b_val), .cbar_b_rdy_i(b_rdy), .cbar_b_data_o(b_data),
        .slv_aw_addr_o(s_aw_addr), .slv_aw_valid_o(s_aw_valid), .slv_aw_ready_i(s_aw_ready),
        .slv_w_data_o(s_w_data), .slv_w_valid_o(s_w_valid), .slv_w_ready_i(s_w_ready),
        .slv_b_resp_i(b_resp), .slv_b_valid_i(s_b_valid), .slv_b_ready_o(s_b_ready),
        .outstanding_o(outstanding), .b_err_o(b_err)
    );

    liteic_slave_node_write_rr #(.CONNECTIVITY(4'b1011)) dut_c (
        .clk_i(clk), .rst_i(rst),
        .cbar_aw_data_i(aw_data), .cbar_aw_val_i(aw_val), .cbar_aw_rdy_o(c_aw_rdy),
        .cbar_w_data_i(w_data), .cbar_w_val_i(w_val), .cbar_w_rdy_o(c_w_rdy),
        .cbar_b_val_o(c_b_val), .cbar_b_rdy_i(b_rdy), .cbar_b_data_o(c_b_data),
        .slv_aw_addr_o(c_aw_addr), .slv_aw_valid_o(c_aw_valid), .slv_aw_ready_i(c_aw_ready),
        .slv_w_data_o(c_w_data), .slv_w_valid_o(c_w_valid), .slv_w_ready_i(c_w_ready),
        .slv_b_resp_i(b_resp), .slv_b_valid_i(c_b_valid), .slv_b_ready_o(c_b_ready),
        .outstanding_o(c_out), .b_err_o(c_b_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        aw_val = '0; w_val = '0; b_rdy = '0; b_resp = '0;
        s_aw_ready = 1'b0; s_w_ready = 1'b0; s_b_valid = 1'b0;
        c_aw_ready = 1'b0; c_w_ready = 1'b0; c_b_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            aw_data[i] = '0;
            w_data[i]  = '0;
        end
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        settle();
        checks++; if (s_aw_valid !== 1'b0) begin errors++; $display("FAIL reset_aw_valid got %b exp 0", s_aw_valid); end
        checks++; if (aw_rdy !== 4'b0000) begin errors++; $display("FAIL reset_aw_rdy got %b exp 0000", aw_rdy); end
        checks++; if (s_w_valid !== 1'b0) begin errors++; $display("FAIL reset_w_valid got %b exp 0", s_w_valid); end
        checks++; if (s_b_ready !== 1'b0) begin errors++; $display("FAIL reset_b_ready got %b exp 0", s_b_ready); end
        checks++; if (b_val !== 4'b0000) begin errors++; $display("FAIL reset_b_val got %b exp 0000", b_val); end
        checks++; if (outstanding !== 2'd0) begin errors++; $display("FAIL reset_outstanding got %0d exp 0", outstanding); end
        checks++; if (b_err !== 1'b0) begin errors++; $display("FAIL reset_b_err got %b exp 0", b_err); end
    endtask

    task automatic test_single_write();
        apply_reset();
        aw_val = 4'b0100; aw_data[2] = 32'h100;
        w_val  = 4'b0100; w_data[2]  = 36'hAB;
        s_aw_ready = 1'b1; s_w_ready = 1'b1;
        settle();
        checks++; if (s_aw_valid !== 1'b1) begin errors++; $display("FAIL single_aw_valid got %b exp 1", s_aw_valid); end
        checks++; if (s_aw_addr !== 32'h100) begin errors++; $display("FAIL single_aw_addr got %h exp 100", s_aw_addr); end
        checks++; if (aw_rdy !== 4'b0100) begin errors++; $display("FAIL single_aw_rdy got %b exp 0100", aw_rdy); end
        checks++; if (s_w_valid !== 1'b1 || s_w_data !== 36'hAB) begin errors++; $display("FAIL single_w got %b/%h exp 1/ab", s_w_valid, s_w_data); end
        checks++; if (w_rdy !== 4'b0100) begin errors++; $display("FAIL single_w_rdy got %b exp 0100", w_rdy); end
        tick();
        aw_val = '0; w_val = '0; s_aw_ready = 1'b0; s_w_ready = 1'b0;
        settle();
        checks++; if (outstanding !== 2'd1) begin errors++; $display("FAIL single_out1 got %0d exp 1", outstanding); end
        checks++; if (s_w_valid !== 1'b0) begin errors++; $display("FAIL single_no_dup_w got %b exp 0", s_w_valid); end
        s_b_valid = 1'b1; b_resp = 2'b00; b_rdy = 4'b0100;
        settle();
        checks++; if (b_val !== 4'b0100) begin errors++; $display("FAIL single_b_val got %b exp 0100", b_val); end
        checks++; if (s_b_ready !== 1'b1 || b_data !== 2'b00) begin errors++; $display("FAIL single_b_ready got %b/%b exp 1/00", s_b_ready, b_data); end
        tick();
        s_b_valid = 1'b0;
        settle();
        checks++; if (outstanding !== 2'd0) begin errors++; $display("FAIL single_out0 got %0d exp 0", outstanding); end
        checks++; if (b_err !== 1'b0) begin errors++; $display("FAIL single_b_err got %b exp 0", b_err); end
    endtask

    task automatic test_round_robin();
        int order [3] = '{0, 1, 3};
        int m;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            aw_data[i] = 32'h1000 * (i + 1);
            w_data[i]  = 36'h500 + 36'(i);
        end
        aw_val = 4'b1011; w_val = 4'b1011; b_rdy = 4'b1111;
        s_aw_ready = 1'b1; s_w_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            s_b_valid = (k != 0);
            settle();
            m = order[k % 3];
            checks++; if (aw_rdy !== (4'b0001 << m)) begin errors++; $display("FAIL rr_grant k=%0d got %b exp m%0d", k, aw_rdy, m); end
            checks++; if (s_aw_addr !== 32'h1000 * (m + 1) || s_w_data !== 36'h500 + 36'(m)) begin errors++; $display("FAIL rr_data k=%0d got %h/%h exp m%0d", k, s_aw_addr, s_w_data, m); end
            if (k != 0) begin
                checks++; if (b_val !== (4'b0001 << order[(k - 1) % 3])) begin errors++; $display("FAIL rr_b k=%0d got %b exp m%0d", k, b_val, order[(k - 1) % 3]); end
            end
            tick();
        end
        aw_val = '0; w_val = '0;
        settle();
        checks++; if (b_val !== 4'b1000 || outstanding !== 2'd1) begin errors++; $display("FAIL rr_tail got %b/%0d exp 1000/1", b_val, outstanding); end
        tick();
        s_b_valid = 1'b0;
        settle();
        checks++; if (outstanding !== 2'd0) begin errors++; $display("FAIL rr_drain got %0d exp 0", outstanding); end
    endtask

    task automatic test_max_outstanding();
        apply_reset();
        aw_val = 4'b0001; aw_data[0] = 32'h80; w_val = 4'b0001; w_data[0] = 36'h88;
        s_aw_ready = 1'b1; s_w_ready = 1'b1;
        tick();
        tick();
        checks++; if (outstanding !== 2'd2) begin errors++; $display("FAIL max_out got %0d exp 2", outstanding); end
        checks++; if (s_aw_valid !== 1'b0 || aw_rdy !== 4'b0000) begin errors++; $display("FAIL max_aw_block got %b/%b exp 0/0000", s_aw_valid, aw_rdy); end
        checks++; if (s_w_valid !== 1'b0) begin errors++; $display("FAIL max_w_block got %b exp 0", s_w_valid); end
        s_b_valid = 1'b1; b_rdy = 4'b1111;
        settle();
        checks++; if (s_b_ready !== 1'b1 || b_val !== 4'b0001) begin errors++; $display("FAIL max_b got %b/%b exp 1/0001", s_b_ready, b_val); end
        checks++; if (s_aw_valid !== 1'b0) begin errors++; $display("FAIL max_no_credit got %b exp 0", s_aw_valid); end
        tick();
        s_b_valid = 1'b0;
        settle();
        checks++; if (outstanding !== 2'd1 || aw_rdy !== 4'b0001) begin errors++; $display("FAIL max_reopen got %0d/%b exp 1/0001", outstanding, aw_rdy); end
        tick();
        aw_val = '0; w_val = '0;
        settle();
        checks++; if (outstanding !== 2'd2) begin errors++; $display("FAIL max_refill got %0d exp 2", outstanding); end
        s_b_valid = 1'b1;
        tick();
        tick();
        s_b_valid = 1'b0;
        settle();
        checks++; if (outstanding !== 2'd0 || b_err !== 1'b0) begin errors++; $display("FAIL max_drain got %0d/%b exp 0/0", outstanding, b_err); end
    endtask

    task automatic test_late_w();
        apply_reset();
        aw_val = 4'b0010; aw_data[1] = 32'h11; w_val = 4'b0010; w_data[1] = 36'h111;
        s_aw_ready = 1'b1; s_w_ready = 1'b0; b_rdy = 4'b1111;
        settle();
        checks++; if (aw_rdy !== 4'b0010 || s_w_data !== 36'h111) begin errors++; $display("FAIL late_aw1 got %b/%h exp 0010/111", aw_rdy, s_w_data); end
        tick();
        aw_val = 4'b1000; aw_data[3] = 32'h33; w_val = 4'b1010; w_data[3] = 36'h333;
        settle();
        checks++; if (aw_rdy !== 4'b1000 || s_w_data !== 36'h111) begin errors++; $display("FAIL late_aw3 got %b/%h exp 1000/111", aw_rdy, s_w_data); end
        tick();
        aw_val = '0; s_w_ready = 1'b1;
        settle();
        checks++; if (s_w_data !== 36'h111 || w_rdy !== 4'b0010) begin errors++; $display("FAIL late_w1 got %h/%b exp 111/0010", s_w_data, w_rdy); end
        tick();
        w_val = 4'b1000;
        settle();
        checks++; if (s_w_data !== 36'h333 || w_rdy !== 4'b1000 || s_w_valid !== 1'b1) begin errors++; $display("FAIL late_w3 got %h/%b exp 333/1000", s_w_data, w_rdy); end
        tick();
        w_val = '0;
        settle();
        checks++; if (s_w_valid !== 1'b0 || outstanding !== 2'd2) begin errors++; $display("FAIL late_idle got %b/%0d exp 0/2", s_w_valid, outstanding); end
        s_b_valid = 1'b1; b_resp = 2'b10;
        settle();
        checks++; if (b_val !== 4'b0010 || b_data !== 2'b10) begin errors++; $display("FAIL late_b1 got %b/%b exp 0010/10", b_val, b_data); end
        tick();
        b_resp = 2'b00;
        settle();
        checks++; if (b_val !== 4'b1000 || b_data !== 2'b00) begin errors++; $display("FAIL late_b3 got %b/%b exp 1000/00", b_val, b_data); end
        tick();
        s_b_valid = 1'b0;
        settle();
        checks++; if (outstanding !== 2'd0 || b_err !== 1'b0) begin errors++; $display("FAIL late_drain got %0d/%b exp 0/0", outstanding, b_err); end
    endtask

    task automatic test_w_ahead();
        apply_reset();
        aw_val = 4'b0001; aw_data[0] = 32'h40; w_val = 4'b0001; w_data[0] = 36'h44;
        s_w_ready = 1'b1; b_rdy = 4'b1111;
        settle();
        checks++; if (s_w_valid !== 1'b1 || w_rdy !== 4'b0001 || aw_rdy !== 4'b0000) begin errors++; $display("FAIL ahead_byp got %b/%b/%b exp 1/0001/0000", s_w_valid, w_rdy, aw_rdy); end
        tick();
        w_data[0] = 36'h45;
        settle();
        checks++; if (s_w_valid !== 1'b0 || w_rdy !== 4'b0000) begin errors++; $display("FAIL ahead_no_dup got %b/%b exp 0/0000", s_w_valid, w_rdy); end
        checks++; if (s_aw_valid !== 1'b1 || s_aw_addr !== 32'h40) begin errors++; $display("FAIL ahead_aw_hold got %b/%h exp 1/40", s_aw_valid, s_aw_addr); end
        s_aw_ready = 1'b1;
        settle();
        checks++; if (aw_rdy !== 4'b0001 || s_w_valid !== 1'b0) begin errors++; $display("FAIL ahead_aw got %b/%b exp 0001/0", aw_rdy, s_w_valid); end
        tick();
        aw_val = 4'b0010; aw_data[1] = 32'h50; w_val = 4'b0010; w_data[1] = 36'h55;
        settle();
        checks++; if (s_w_data !== 36'h55 || w_rdy !== 4'b0010 || outstanding !== 2'd1) begin errors++; $display("FAIL ahead_next got %h/%b/%0d exp 55/0010/1", s_w_data, w_rdy, outstanding); end
        tick();
        aw_val = '0; w_val = '0; s_b_valid = 1'b1;
        settle();
        checks++; if (b_val !== 4'b0001) begin errors++; $display("FAIL ahead_b0 got %b exp 0001", b_val); end
        tick();
        settle();
        checks++; if (b_val !== 4'b0010) begin errors++; $display("FAIL ahead_b1 got %b exp 0010", b_val); end
        tick();
        s_b_valid = 1'b0;
        settle();
        checks++; if (outstanding !== 2'd0) begin errors++; $display("FAIL ahead_drain got %0d exp 0", outstanding); end
    endtask

    task automatic test_connectivity();
        apply_reset();
        aw_val = 4'b0100; aw_data[2] = 32'h200; c_aw_ready = 1'b1;
        settle();
        checks++; if (c_aw_valid !== 1'b0 || c_aw_rdy !== 4'b0000) begin errors++; $display("FAIL conn_block got %b/%b exp 0/0000", c_aw_valid, c_aw_rdy); end
        tick();
        checks++; if (c_aw_rdy[2] !== 1'b0 || c_out !== 3'd0) begin errors++; $display("FAIL conn_hold got %b/%0d exp 0/0", c_aw_rdy[2], c_out); end
        c_b_valid = 1'b1;
        settle();
        checks++; if (c_b_ready !== 1'b0 || c_b_val !== 4'b0000) begin errors++; $display("FAIL conn_b_idle got %b/%b exp 0/0000", c_b_ready, c_b_val); end
        tick();
        c_b_valid = 1'b0;
        settle();
        checks++; if (c_b_err !== 1'b1) begin errors++; $display("FAIL conn_b_err got %b exp 1", c_b_err); end
        tick();
        checks++; if (c_b_err !== 1'b1) begin errors++; $display("FAIL conn_b_err_sticky got %b exp 1", c_b_err); end
        c_aw_ready = 1'b0; aw_val = 4'b0101; aw_data[0] = 32'hC0;
        settle();
        checks++; if (c_aw_valid !== 1'b1 || c_aw_addr !== 32'hC0) begin errors++; $display("FAIL conn_m0 got %b/%h exp 1/c0", c_aw_valid, c_aw_addr); end
        apply_reset();
        settle();
        checks++; if (c_b_err !== 1'b0) begin errors++; $display("FAIL conn_b_err_clr got %b exp 0", c_b_err); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_max_outstanding();
        test_late_w();
        test_w_ahead();
        test_connectivity();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
